// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int unsigned DEF_DATAWIDTH = 8;
  localparam int unsigned DEF_DEPTH     = 16;

  // Read-mode encodings for the SHOWAHEAD parameter
  localparam int unsigned REG_READ = 0;
  localparam int unsigned FWFT     = 1;

  // Ceiling log2 with a fixed loop bound so it elaborates as a constant
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = unsigned'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Pointer counter that wraps from DEPTH-1 to 0, for any DEPTH.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q, ptr_d;

  // clr has priority so a flush always lands the pointer at 0
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags, sticky errors,
// synchronous flush and registered or first-word-fall-through read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter  int unsigned DATAWIDTH     = DEF_DATAWIDTH,
  parameter  int unsigned DEPTH         = DEF_DEPTH,
  parameter  int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter  int unsigned AEMPTY_THRESH = 2,
  parameter  int unsigned SHOWAHEAD     = REG_READ,
  localparam int unsigned AW            = clog2(DEPTH),
  localparam int unsigned CW            = clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [DATAWIDTH-1:0] datain,
  input  logic                 r_en,
  output logic [DATAWIDTH-1:0] dataout,
  output logic                 rvalid,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CW-1:0]        count,
  output logic                 overflow,
  output logic                 underflow
);

  logic [AW-1:0]        wptr, rptr;
  logic                 wr_ok, rd_ok;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic                 afull_q, afull_d, aempty_q, aempty_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic                 rvalid_q, rvalid_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_ok),
    .clr (flush),
    .ptr (wptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_ok),
    .clr (flush),
    .ptr (rptr)
  );

  // Accepts use last edge's flags; flags are derived from next count
  always_comb begin
    wr_ok   = w_en & ~full_q & ~flush;
    rd_ok   = r_en & ~empty_q & ~flush;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CW'(1);
    end
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_THRESH));
    aempty_d = (count_d <= CW'(AEMPTY_THRESH));

    // Errors hold across a flush; a new error wins over clr_err
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!flush) begin
      if (w_en && full_q)  ovf_d = 1'b1;
      else if (clr_err)    ovf_d = 1'b0;
      if (r_en && empty_q) unf_d = 1'b1;
      else if (clr_err)    unf_d = 1'b0;
    end

    rvalid_d = rd_ok && (SHOWAHEAD == REG_READ);
    dout_d   = dout_q;
    if (rd_ok) dout_d = mem_q[rptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= rvalid_d;
      dout_q   <= dout_d;
    end
  end

  // Storage carries no reset; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr] <= datain;
  end

  // Showahead output is masked while empty so reset drives zero
  assign dataout      = (SHOWAHEAD == FWFT) ? (empty_q ? '0 : mem_q[rptr]) : dout_q;
  assign rvalid       = rvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
